sram_responder: RTL and testbench

Memory-side responder for the state controller's RAM request interface. Accepts single-word write and read requests on the `wr_*`/`rd_*` ports using the `busy`/`rd_ready` handshake, and runs the matching cycle on an external asynchronous 16-bit SRAM. It sits between the SPI state controller and the SRAM pins and owns all SRAM timing.

---
 rtl/sram_responder_if.sv | 13 +
 rtl/sram_responder.sv | 110 +++++++++++
 tb/tb_sram_responder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sram_responder_if.sv
// sram_responder_if: request bus (wr_*/rd_* requests, rd_data/rd_ready/busy responses); master=initiator, slave=responder
interface sram_responder_if;
  logic [23:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_enable;
  logic [23:0] rd_addr;
  logic        rd_enable;
  logic [15:0] rd_data;
  logic        rd_ready;
  logic        busy;
  modport master (output wr_addr, wr_data, wr_enable, rd_addr, rd_enable, input rd_data, rd_ready, busy);
  modport slave (input wr_addr, wr_data, wr_enable, rd_addr, rd_enable, output rd_data, rd_ready, busy);
endinterface

// File: rtl/sram_responder.sv
// sram_responder: runs single-word SRAM cycles for req (slave) requests; clk/rst, sram_addr/dq_out/dq_oe/dq_in, active-low ce/oe/we/ub/lb strobes
module sram_responder #(
  parameter int ADDR_W      = 20,
  parameter int WR_WAIT     = 2,
  parameter int RD_WAIT     = 2,
  parameter int TURN        = 1,
  parameter int INIT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  sram_responder_if.slave   req,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);
  typedef enum logic [2:0] {INIT, IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS, RELEASE, GAP} state_e;
  state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic op_wr_q, rd_last, act_d, wr_d, accept, unused_hi;
  assign unused_hi = ^{req.wr_addr, req.rd_addr};
  assign accept = state_q == IDLE && (req.wr_enable || req.rd_enable);
  assign rd_last = state_q == RD_ACCESS && cnt_q == 16'(RD_WAIT - 1);
  assign act_d = state_d inside {WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS};
  assign wr_d = state_d inside {WR_SETUP, WR_PULSE, WR_HOLD};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 16'd1;
    case (state_q)
      INIT: if (cnt_q == 16'(INIT_CYCLES - 1)) begin
        state_d = IDLE;
        cnt_d = '0;
      end
      IDLE: begin
        cnt_d = '0;
        state_d = req.wr_enable ? WR_SETUP : req.rd_enable ? RD_ACCESS : IDLE;
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d = '0;
      end
      WR_PULSE: if (cnt_q == 16'(WR_WAIT - 1)) begin
        state_d = WR_HOLD;
        cnt_d = '0;
      end
      WR_HOLD: begin
        state_d = RELEASE;
        cnt_d = '0;
      end
      RD_ACCESS: if (rd_last) begin
        state_d = RELEASE;
        cnt_d = '0;
      end
      RELEASE: begin
        cnt_d = '0;
        // hold here until the initiator lets go of the enable we served
        if (!(op_wr_q ? req.wr_enable : req.rd_enable)) state_d = TURN == 0 ? IDLE : GAP;
      end
      GAP: if (cnt_q == 16'(TURN - 1)) begin
        state_d = IDLE;
        cnt_d = '0;
      end
      default: state_d = INIT;
    endcase
  end
  // strobes are registered from the next state so they line up with state_q
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q <= '0;
      op_wr_q <= 1'b0;
      sram_addr <= '0;
      sram_dq_out <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_ub_n <= 1'b1;
      sram_lb_n <= 1'b1;
      req.rd_data <= '0;
      req.rd_ready <= 1'b0;
      req.busy <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (accept) begin
        op_wr_q <= req.wr_enable;
        sram_addr <= req.wr_enable ? req.wr_addr[ADDR_W-1:0] : req.rd_addr[ADDR_W-1:0];
        if (req.wr_enable) sram_dq_out <= req.wr_data;
        req.rd_ready <= 1'b0;
      end
      if (rd_last) begin
        req.rd_data <= sram_dq_in;
        req.rd_ready <= 1'b1;
      end
      req.busy <= state_d != IDLE;
      sram_dq_oe <= wr_d;
      sram_ce_n <= !act_d;
      sram_ub_n <= !act_d;
      sram_lb_n <= !act_d;
      sram_we_n <= state_d != WR_PULSE;
      sram_oe_n <= state_d != RD_ACCESS;
    end
  end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed self-checking bench for sram_responder with a small SRAM model
module tb_sram_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  int checks = 0;
  int failures = 0;
  int viol = 0;
  logic [31:0] v_we, v_oe, v_ce, v_lb, v_dqoe, v_busy, v_rdy;
  logic [15:0] mem [256];
  logic [255:0] written;
  sram_responder_if bus ();
  sram_responder dut (
    .clk(clk), .rst(rst), .req(bus.slave),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst) written <= '0;
    else if (!sram_ce_n && !sram_we_n) begin
      mem[sram_addr[7:0]] <= sram_dq_out;
      written[sram_addr[7:0]] <= 1'b1;
    end
  end
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ?
    (written[sram_addr[7:0]] ? mem[sram_addr[7:0]] : {8'hA5, sram_addr[7:0]}) : 16'h0000;
  always @(negedge clk) if (!rst && ((!sram_we_n && !sram_oe_n) || (sram_dq_oe && !sram_oe_n))) viol++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask
  task automatic trace(input int n, input int rd_mode);
    {v_we, v_oe, v_ce, v_lb, v_dqoe, v_busy, v_rdy} = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      v_we[k-1] = sram_we_n;
      v_oe[k-1] = sram_oe_n;
      v_ce[k-1] = sram_ce_n;
      v_lb[k-1] = sram_lb_n;
      v_dqoe[k-1] = sram_dq_oe;
      v_busy[k-1] = bus.busy;
      v_rdy[k-1] = bus.rd_ready;
      if (bus.busy) bus.wr_enable = 1'b0;
      if ((rd_mode == 0 && bus.busy) || (rd_mode == 1 && bus.rd_ready) || (rd_mode == 2 && k == 20)) bus.rd_enable = 1'b0;
    end
  endtask
  task automatic init_wait(input string tag);
    int n = 0;
    int bad = 0;
    int we_low = 0;
    while (bus.busy && n < 40) begin
      n++;
      if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} != 5'b11111) bad++;
      @(negedge clk);
    end
    chk({tag, "_len"}, n, 16);
    chk({tag, "_strobes"}, bad, 0);
    repeat (5) begin
      if (!sram_we_n) we_low++;
      @(negedge clk);
    end
    chk({tag, "_idle_we"}, we_low, 0);
  endtask
  initial begin
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_enable = 1'b0;
    bus.rd_addr = '0;
    bus.rd_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1);
    chk("rst_rd_ready", bus.rd_ready, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dq_out", sram_dq_out, 0);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
    rst = 1'b0;
    init_wait("init");
    bus.wr_addr = 24'h012345;
    bus.wr_data = 16'hBEEF;
    bus.wr_enable = 1'b1;
    @(negedge clk);
    chk("wr_addr", sram_addr, 20'h12345);
    chk("wr_dq_out", sram_dq_out, 16'hBEEF);
    bus.wr_enable = 1'b0;
    trace(7, 0);
    chk("wr_we_n", {v_we[6:0], 1'b1}, 8'hF9);
    chk("wr_ce_n", {v_ce[6:0], 1'b0}, 8'hF0);
    chk("wr_lb_n", {v_lb[6:0], 1'b0}, 8'hF0);
    chk("wr_dq_oe", {v_dqoe[6:0], 1'b1}, 8'h0F);
    chk("wr_oe_n", {v_oe[6:0], 1'b1}, 8'hFF);
    chk("wr_busy", {v_busy[6:0], 1'b1}, 8'h3F);
    bus.rd_addr = 24'h012345;
    bus.rd_enable = 1'b1;
    trace(8, 0);
    chk("rd_oe_n", v_oe, 32'hFC);
    chk("rd_we_n", v_we, 32'hFF);
    chk("rd_dq_oe", v_dqoe, 32'h00);
    chk("rd_busy", v_busy, 32'h0F);
    chk("rd_ready", v_rdy, 32'hFC);
    chk("rd_data", bus.rd_data, 16'hBEEF);
    bus.wr_addr = 24'h000010;
    bus.wr_data = 16'h1111;
    bus.rd_addr = 24'h000020;
    chk("held_rd_ready", bus.rd_ready, 1);
    chk("held_rd_data", bus.rd_data, 16'hBEEF);
    bus.wr_enable = 1'b1;
    bus.rd_enable = 1'b1;
    trace(16, 1);
    chk("both_we_n", v_we, 32'hFFF9);
    chk("both_oe_n", v_oe, 32'hFE7F);
    chk("both_busy", v_busy, 32'h07BF);
    chk("both_rd_ready", v_rdy, 32'hFE00);
    chk("both_rd_data", bus.rd_data, 16'hA520);
    chk("both_mem", {written[8'h10], mem[8'h10]}, 17'h11111);
    bus.rd_addr = 24'h012345;
    bus.rd_enable = 1'b1;
    trace(24, 2);
    chk("hold_oe_cycles", 24 - $countones(v_oe), 2);
    chk("hold_busy_cycles", $countones(v_busy), 21);
    chk("hold_busy_end", v_busy[21:19], 3'b011);
    chk("hold_rd_data", bus.rd_data, 16'hBEEF);
    bus.wr_addr = 24'h000033;
    bus.wr_data = 16'h5A5A;
    bus.wr_enable = 1'b1;
    @(negedge clk);
    if (bus.busy) bus.wr_enable = 1'b0;
    @(negedge clk);
    chk("mid_pulse_we_n", sram_we_n, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_strobes", {sram_we_n, sram_ce_n, sram_dq_oe, bus.busy}, 4'b1101);
    rst = 1'b0;
    init_wait("reinit");
    chk("protocol_viol", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
